// File: rtl/apb4_slave_waitstate_if.sv
// APB4 completer front-end: latches each setup phase, decodes it against a block window,
// issues a one-cycle request to the register file and stretches PREADY until ack or timeout.
module apb4_slave_waitstate_if #(
  parameter int unsigned DATA_W              = 32,
  parameter int unsigned LOCAL_AW            = 12,
  parameter logic [31:0] BLOCK_START_ADDRESS = 32'h0000_0000,
  parameter int unsigned TIMEOUT             = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic [31:0]           PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W/8-1:0]   PSTRB,
  output logic [DATA_W-1:0]     PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  wen,
  output logic                  ren,
  output logic [LOCAL_AW-1:0]   addr,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  reg_ack,
  input  logic                  reg_err
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);
  localparam logic [31:0] WIN_MASK = ~((32'd1 << LOCAL_AW) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ERR,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [LOCAL_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                wen_q, wen_d;
  logic                ren_q, ren_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;

  logic setup;
  logic hit;
  logic timeout_hit;

  assign setup       = PSELx && !PENABLE;
  assign hit         = (PADDR & WIN_MASK) == BLOCK_START_ADDRESS;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave one unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wen_d     = 1'b0;
    ren_d     = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          addr_d  = PADDR[LOCAL_AW-1:0];
          wdata_d = PWDATA;
          wstrb_d = PWRITE ? PSTRB : '0;
          write_d = PWRITE;
          if (hit) begin
            wen_d   = PWRITE;
            ren_d   = !PWRITE;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = S_ERR;
          end
        end
      end

      S_BUSY: begin
        // Ack is checked before the timeout so a same-cycle ack still completes normally.
        if (!PSELx) begin
          state_d = S_IDLE;
          addr_d  = '0;
          wdata_d = '0;
          wstrb_d = '0;
          write_d = 1'b0;
        end else if (reg_ack) begin
          pready_d  = 1'b1;
          pslverr_d = reg_err;
          prdata_d  = write_q ? '0 : rdata;
          state_d   = S_RESP;
        end else if (timeout_hit) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = S_RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ERR, S_RESP: begin
        state_d = S_IDLE;
        if (!PSELx) begin
          addr_d  = '0;
          wdata_d = '0;
          wstrb_d = '0;
          write_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign wen     = wen_q;
  assign ren     = ren_q;
  assign addr    = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;

endmodule

// File: tb/tb_apb4_slave_waitstate_if.sv
// Self-checking bench: transaction-level model of the wait-state APB completer,
// randomized traffic plus directed cases with literal expectations.
module tb_apb4_slave_waitstate_if;

  localparam int          DW   = 32;
  localparam int          AW   = 12;
  localparam int          TO   = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          PSELx, PENABLE, PWRITE;
  logic [31:0]   PADDR;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR, wen, ren;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic [DW-1:0] rdata;
  logic          reg_ack, reg_err;

  apb4_slave_waitstate_if #(
    .DATA_W(DW), .LOCAL_AW(AW), .BLOCK_START_ADDRESS(BASE), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .wen(wen), .ren(ren), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .reg_ack(reg_ack), .reg_err(reg_err)
  );

  always #5 PCLK = ~PCLK;

  int vectors = 0;
  int miscompares = 0;

  // Expected outputs for the current cycle, written by the driver just after each rising edge.
  bit          exp_on = 1'b0;
  bit          e_lat_on = 1'b0;
  bit          e_pready, e_pslverr, e_wen, e_ren;
  logic [31:0] e_prdata, e_addr, e_wdata, e_wstrb;

  int          txn_cyc = 0;
  int          obs_resp_cyc, obs_wen_cnt, obs_ren_cnt, obs_wen_cyc, obs_ren_cyc;
  logic [31:0] obs_prdata;
  logic        obs_pslverr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge PCLK) begin
    if (exp_on) begin
      check("PREADY",  32'(PREADY),  32'(e_pready));
      check("PSLVERR", 32'(PSLVERR), 32'(e_pslverr));
      check("wen",     32'(wen),     32'(e_wen));
      check("ren",     32'(ren),     32'(e_ren));
      check("PRDATA",  PRDATA,       e_prdata);
      if (e_lat_on) begin
        check("addr",  32'(addr),  e_addr);
        check("wdata", wdata,      e_wdata);
        check("wstrb", 32'(wstrb), e_wstrb);
      end
      if (PREADY === 1'b1) begin
        obs_resp_cyc = txn_cyc;
        obs_prdata   = PRDATA;
        obs_pslverr  = PSLVERR;
      end
      if (wen === 1'b1) begin obs_wen_cnt++; obs_wen_cyc = txn_cyc; end
      if (ren === 1'b1) begin obs_ren_cnt++; obs_ren_cyc = txn_cyc; end
    end
  end

  task automatic step();
    @(posedge PCLK);
    #1;
    txn_cyc++;
  endtask

  task automatic set_exp(input bit rdy, input bit err, input bit w, input bit r, input logic [31:0] prd);
    e_pready  = rdy;
    e_pslverr = err;
    e_wen     = w;
    e_ren     = r;
    e_prdata  = prd;
  endtask

  task automatic noise();
    reg_ack = 1'($urandom_range(0, 1));
    reg_err = 1'($urandom_range(0, 1));
    rdata   = $urandom;
  endtask

  task automatic idle(input int n, input bit force_ack);
    for (int i = 0; i < n; i++) begin
      step();
      PSELx = 1'b0; PENABLE = 1'b0;
      noise();
      if (force_ack) reg_ack = 1'b1;
      e_lat_on = 1'b0;
      set_exp(0, 0, 0, 0, 32'h0);
    end
  endtask

  // One APB transfer. d = cycles after T1 before reg_ack (-1 = never); abort_at = access
  // cycle in which the master drops PSELx (-1 = never).
  task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd, input logic [3:0] st,
                      input int d, input bit err, input logic [31:0] ack_data, input int abort_at);
    bit          hit, to;
    int          r;
    logic [31:0] rd_cap;
    hit = ((a >> AW) == (BASE >> AW));
    step();
    txn_cyc = 0;
    obs_resp_cyc = -1; obs_wen_cnt = 0; obs_ren_cnt = 0; obs_wen_cyc = -1; obs_ren_cyc = -1;
    obs_prdata = 32'hx; obs_pslverr = 1'bx;
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = wd; PSTRB = st;
    noise();
    e_lat_on = 1'b0;
    set_exp(0, 0, 0, 0, 32'h0);
    e_addr  = 32'(a[AW-1:0]);
    e_wdata = wd;
    e_wstrb = wr ? 32'(st) : 32'h0;
    if (!hit) begin
      step();
      PENABLE = 1'b1;
      noise();
      e_lat_on = 1'b1;
      set_exp(1, 1, 0, 0, 32'h0);
      return;
    end
    to = !(d >= 0 && d <= TO - 1);
    r  = to ? TO + 1 : d + 2;
    rd_cap = 32'h0;
    for (int k = 1; k <= r; k++) begin
      step();
      PENABLE = 1'b1;
      noise();
      e_lat_on = 1'b1;
      if (k == abort_at) begin
        set_exp(0, 0, wr && k == 1, !wr && k == 1, 32'h0);
        PSELx = 1'b0; PENABLE = 1'b0; reg_ack = 1'b0;
        step();
        reg_ack = 1'b1;
        e_lat_on = 1'b0;
        set_exp(0, 0, 0, 0, 32'h0);
        step();
        reg_ack = 1'b0;
        set_exp(0, 0, 0, 0, 32'h0);
        return;
      end
      if (k < r) begin
        reg_ack = (k == d + 1);
        if (k == d + 1) begin
          rdata   = ack_data;
          reg_err = err;
          rd_cap  = ack_data;
        end
      end
      set_exp(k == r, k == r && (to || err), wr && k == 1, !wr && k == 1,
              (k == r && !to && !wr) ? rd_cap : 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0;
    PWDATA = '0; PSTRB = '0; rdata = '0; reg_ack = 1'b0; reg_err = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_PREADY",  32'(PREADY),  32'h0);
    check("rst_PSLVERR", 32'(PSLVERR), 32'h0);
    check("rst_wen",     32'(wen),     32'h0);
    check("rst_ren",     32'(ren),     32'h0);
    check("rst_PRDATA",  PRDATA,       32'h0);
    check("rst_addr",    32'(addr),    32'h0);
    PRESETn = 1'b1;
    set_exp(0, 0, 0, 0, 32'h0);
    exp_on = 1'b1;
    idle(2, 0);

    // Write hit, ack at T1: three cycles per transfer.
    xfer(BASE + 32'h10, 1, 32'hA5A5_0001, 4'b0011, 0, 0, 32'h0, -1);
    idle(1, 0);
    check("wr_wen_pulses", 32'(obs_wen_cnt), 32'd1);
    check("wr_wen_cycle",  32'(obs_wen_cyc), 32'd1);
    check("wr_resp_cycle", 32'(obs_resp_cyc), 32'd2);
    check("wr_pslverr",    32'(obs_pslverr), 32'h0);
    check("wr_addr",       32'(addr),  32'h010);
    check("wr_wstrb",      32'(wstrb), 32'h3);

    // Read hit, ack at T3: PREADY at T4.
    xfer(BASE + 32'h24, 0, 32'h0, 4'hF, 2, 0, 32'hDEAD_BEEF, -1);
    idle(1, 0);
    check("rd_ren_pulses", 32'(obs_ren_cnt), 32'd1);
    check("rd_ren_cycle",  32'(obs_ren_cyc), 32'd1);
    check("rd_resp_cycle", 32'(obs_resp_cyc), 32'd4);
    check("rd_prdata",     obs_prdata, 32'hDEAD_BEEF);

    // Miss just past the window.
    xfer(BASE + 32'h1000, 0, 32'h0, 4'h0, 0, 0, 32'h1111_2222, -1);
    idle(1, 0);
    check("miss_resp_cycle", 32'(obs_resp_cyc), 32'd1);
    check("miss_pslverr",    32'(obs_pslverr), 32'h1);
    check("miss_prdata",     obs_prdata, 32'h0);
    check("miss_requests",   32'(obs_wen_cnt + obs_ren_cnt), 32'd0);

    // Timeout, then a stray ack at T7, then a normal transfer.
    xfer(BASE + 32'h40, 0, 32'h0, 4'h0, -1, 0, 32'h0, -1);
    idle(1, 0);
    idle(1, 1);
    check("to_resp_cycle", 32'(obs_resp_cyc), 32'd5);
    check("to_pslverr",    32'(obs_pslverr), 32'h1);
    xfer(BASE + 32'h44, 1, 32'h0BAD_F00D, 4'hF, 0, 0, 32'h0, -1);
    idle(1, 0);
    check("post_to_resp_cycle", 32'(obs_resp_cyc), 32'd2);
    check("post_to_pslverr",    32'(obs_pslverr), 32'h0);

    // Register-file error on a read, and ack coinciding with timeout expiry.
    xfer(BASE + 32'h80, 0, 32'h0, 4'h0, 0, 1, 32'h1234_5678, -1);
    idle(1, 0);
    check("rerr_pslverr", 32'(obs_pslverr), 32'h1);
    check("rerr_prdata",  obs_prdata, 32'h1234_5678);
    xfer(BASE + 32'h84, 0, 32'h0, 4'h0, TO - 1, 0, 32'hCAFE_0042, -1);
    idle(1, 0);
    check("race_resp_cycle", 32'(obs_resp_cyc), 32'd5);
    check("race_pslverr",    32'(obs_pslverr), 32'h0);
    check("race_prdata",     obs_prdata, 32'hCAFE_0042);

    // Master drops PSELx mid-transfer; the late ack must be ignored.
    xfer(BASE + 32'h88, 0, 32'h0, 4'h0, -1, 0, 32'h0, 2);
    idle(2, 0);

    // Reset pulse while the write request is live in T1.
    step();
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = BASE + 32'h20; PWRITE = 1'b1;
    PWDATA = 32'h5555_AAAA; PSTRB = 4'hF; reg_ack = 1'b0;
    e_lat_on = 1'b0;
    set_exp(0, 0, 0, 0, 32'h0);
    step();
    exp_on = 1'b0;
    PENABLE = 1'b1;
    check("pre_rst_wen", 32'(wen), 32'h1);
    #1 PRESETn = 1'b0;
    #1;
    check("async_rst_wen",     32'(wen),     32'h0);
    check("async_rst_ren",     32'(ren),     32'h0);
    check("async_rst_PREADY",  32'(PREADY),  32'h0);
    check("async_rst_PSLVERR", 32'(PSLVERR), 32'h0);
    check("async_rst_PRDATA",  PRDATA,       32'h0);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1; PSELx = 1'b0; PENABLE = 1'b0;
    set_exp(0, 0, 0, 0, 32'h0);
    exp_on = 1'b1;
    idle(3, 0);
    xfer(BASE + 32'h30, 1, 32'h7777_0000, 4'b1100, 0, 0, 32'h0, -1);
    idle(1, 0);
    check("post_rst_resp_cycle", 32'(obs_resp_cyc), 32'd2);
    check("post_rst_wen_pulses", 32'(obs_wen_cnt), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      bit          wr, to;
      int          d, r, ab;
      if ($urandom_range(0, 9) < 8) begin
        a = BASE | ($urandom & 32'h0000_0FFF);
      end else begin
        a = $urandom;
        if ((a >> AW) == (BASE >> AW)) a = a ^ 32'h8000_0000;
      end
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) d = -1;
      else d = int'($urandom_range(0, TO + 2));
      to = !(d >= 0 && d <= TO - 1);
      r  = to ? TO + 1 : d + 2;
      ab = -1;
      if ($urandom_range(0, 19) == 0 && r > 1) ab = int'($urandom_range(1, r - 1));
      xfer(a, wr, $urandom, 4'($urandom), d, 1'($urandom_range(0, 1)), $urandom, ab);
      idle(int'($urandom_range(0, 2)), 0);
    end

    idle(1, 0);
    @(posedge PCLK);
    exp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
